gluecell_ctrl: RTL

GLUECELL_CTRL -- requirements
Module: gluecell_ctrl

---
 rtl/gluecell_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/gluecell_ctrl.sv
// gluecell_ctrl -- arms, monitors and self-tests a bank of glue-logic detector cells.
//
// Ports
//   clk           block clock; all logic on the rising edge
//   resetn        asynchronous active-low reset
//   cfg_en        level; 1 = cells armed and monitored, 0 = return to IDLE
//   selftest_req  single-cycle pulse requesting a self-test
//   flag_clr      [NCELL] write-1-to-clear for flags
//   a2d_glue_out  [NCELL] per-cell detector outputs
//   d2a_glue_in   [NCELL] per-cell test injection
//   d2a_nrst      [NCELL] per-cell clear, active low
//   flags         [NCELL] sticky detections
//   alarm         registered OR of flags
//   testfail      [NCELL] failing cells from the last completed self-test
//   test_done     one-cycle pulse at the end of a self-test
//   busy          1 while clearing, settling or testing
//
// Build option
//   GLUECELL_INPUT_SYNC_EN  when defined, a2d_glue_out passes a 2-flop
//                           synchronizer before sampling (3-cycle
//                           detection-to-flag latency instead of 1).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cells held in clear, nothing monitored
// CLR   | cells held in clear for RSTLEN cycles (re-arm)
// SETL  | cells released, detector outputs blanked for SETTLE cycles
// MON   | monitoring; a detection sets flags and re-arms
// TDRV  | injection driven high for TESTLEN cycles, result sampled at end
// TCLR  | injection released, test_done pulsed, then re-arm

module gluecell_ctrl #(
  parameter int NCELL   = 8,
  parameter int RSTLEN  = 4,
  parameter int SETTLE  = 8,
  parameter int TESTLEN = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_en,
  input  logic             selftest_req,
  input  logic [NCELL-1:0] flag_clr,
  input  logic [NCELL-1:0] a2d_glue_out,
  output logic [NCELL-1:0] d2a_glue_in,
  output logic [NCELL-1:0] d2a_nrst,
  output logic [NCELL-1:0] flags,
  output logic             alarm,
  output logic [NCELL-1:0] testfail,
  output logic             test_done,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLR, SETL, MON, TDRV, TCLR} state_t;

  // Down-counter load values: the phase ends when the counter reads zero.
  localparam logic [7:0] RST_LD  = 8'(RSTLEN - 1);
  localparam logic [7:0] SETL_LD = 8'(SETTLE - 1);
  localparam logic [7:0] TEST_LD = 8'(TESTLEN - 1);

  state_t           state, nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             pending, pend_nxt;
  logic [NCELL-1:0] glue_s;
  logic [NCELL-1:0] detect;
  logic [NCELL-1:0] tf_nxt;

`ifdef GLUECELL_INPUT_SYNC_EN
  logic [NCELL-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= a2d_glue_out;
      sync2 <= sync1;
    end
  end

  assign glue_s = sync2;
`else
  assign glue_s = a2d_glue_out;
`endif

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    pend_nxt = pending;
    tf_nxt   = testfail;
    detect   = '0;
    if (!cfg_en) begin
      nxt      = IDLE;
      cnt_nxt  = '0;
      pend_nxt = 1'b0;
    end else begin
      // Requests arriving outside a direct MON launch wait for the next SETL exit.
      if (selftest_req) pend_nxt = 1'b1;
      case (state)
        IDLE: begin
          nxt     = CLR;
          cnt_nxt = RST_LD;
        end
        CLR: begin
          if (cnt == 8'd0) begin
            nxt     = SETL;
            cnt_nxt = SETL_LD;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        SETL: begin
          if (cnt == 8'd0) begin
            if (pending || selftest_req) begin
              nxt      = TDRV;
              cnt_nxt  = TEST_LD;
              pend_nxt = 1'b0;
            end else begin
              nxt = MON;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        MON: begin
          if (|glue_s) begin
            detect  = glue_s;
            nxt     = CLR;
            cnt_nxt = RST_LD;
          end else if (selftest_req || pending) begin
            nxt      = TDRV;
            cnt_nxt  = TEST_LD;
            pend_nxt = 1'b0;
          end
        end
        TDRV: begin
          if (cnt == 8'd0) begin
            tf_nxt = ~glue_s;
            nxt    = TCLR;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        TCLR: begin
          nxt     = CLR;
          cnt_nxt = RST_LD;
        end
        default: begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      d2a_nrst    <= '0;
      d2a_glue_in <= '0;
      flags       <= '0;
      alarm       <= 1'b0;
      testfail    <= '0;
      test_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_nxt;
      pending     <= pend_nxt;
      testfail    <= tf_nxt;
      // Set has priority over clear on the same bit.
      flags       <= (flags & ~flag_clr) | detect;
      alarm       <= |flags;
      d2a_nrst    <= (nxt == IDLE || nxt == CLR) ? '0 : '1;
      d2a_glue_in <= (nxt == TDRV) ? '1 : '0;
      test_done   <= (nxt == TCLR);
      busy        <= (nxt inside {CLR, SETL, TDRV, TCLR});
    end
  end

endmodule
